// File: rtl/uart_rx_core.sv
// UART 8N1 receive front-end: synchronises rx, validates the start bit at mid-bit,
// samples eight data bits LSB first and checks the stop bit.
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 434,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic [7:0] rx_byte_o,
   output logic       received_o,
   output logic       is_receiving_o,
   output logic       recv_error_o
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   logic [2:0]    state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [2:0]    bit_q,      bit_d;
   logic [7:0]    shift_q,    shift_d;
   logic [7:0]    byte_q,     byte_d;
   logic          received_q, received_d;
   logic          busy_q,     busy_d;
   logic          err_q,      err_d;

   // Idle-high reset value keeps a reset release from looking like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_d     = byte_q;
      busy_d     = busy_q;
      received_d = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end

         // Re-check the line half a bit in so glitches are rejected as false starts.
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_DATA;
                  bit_d   = 3'd0;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d  = '0;
               busy_d = 1'b0;
               if (rx_s) begin
                  byte_d     = shift_q;
                  received_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         // A held-low line must return high before another start can be seen.
         S_BREAK: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= 3'd0;
         shift_q    <= 8'h00;
         byte_q     <= 8'h00;
         received_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_q     <= byte_d;
         received_q <= received_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign rx_byte_o      = byte_q;
   assign received_o     = received_q;
   assign is_receiving_o = busy_q;
   assign recv_error_o   = err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core at 16 clocks per bit: good frames,
// false start, framing error with break, back-to-back frames and mid-frame reset.
module tb_uart_rx_core;

   localparam int CPB = 16;

   logic       clk;
   logic       rst_n;
   logic       rx_i;
   logic [7:0] rx_byte_o;
   logic       received_o;
   logic       is_receiving_o;
   logic       recv_error_o;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int recvCount = 0;
   int errCount = 0;
   int overlapCount = 0;
   int recvCycle = 0;
   int frameStart = 0;
   logic prevRecv = 1'b0;
   logic prevErr = 1'b0;
   logic [7:0] byteLog[$];
   logic [7:0] abortData;

   uart_rx_core #(
      .CLKS_PER_BIT(CPB),
      .SYNC_STAGES (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_i          (rx_i),
      .rx_byte_o     (rx_byte_o),
      .received_o    (received_o),
      .is_receiving_o(is_receiving_o),
      .recv_error_o  (recv_error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Strobes are tallied on the falling edge, away from the register updates.
   always @(negedge clk) begin
      if (received_o) begin
         recvCount++;
         recvCycle = cycle;
         byteLog.push_back(rx_byte_o);
      end
      if (recv_error_o) errCount++;
      if ((received_o && recv_error_o) || (received_o && prevErr) || (recv_error_o && prevRecv))
         overlapCount++;
      prevRecv = received_o;
      prevErr  = recv_error_o;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      logic [9:0] bits;
      bits = {stopBit, data, 1'b0};
      frameStart = cycle;
      for (int i = 0; i < 10; i++) begin
         rx_i = bits[i];
         waitCycles(CPB);
         if (i == 4) checkOutput("busyMidFrame", 32'(is_receiving_o), 32'd1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rx_i  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 rx_i = ~rx_i;
      end
      checkOutput("resetByte", 32'(rx_byte_o), 32'h00);
      checkOutput("resetRecv", 32'(received_o), 32'd0);
      checkOutput("resetBusy", 32'(is_receiving_o), 32'd0);
      checkOutput("resetErr", 32'(recv_error_o), 32'd0);
      rx_i = 1'b1;
      waitCycles(2);
      rst_n = 1'b1;
      waitCycles(5);
      checkOutput("idleBusy", 32'(is_receiving_o), 32'd0);

      applyStimulus(8'h55, 1'b1);
      waitCycles(4);
      checkOutput("frame55Count", 32'(recvCount), 32'd1);
      checkOutput("frame55Byte", 32'(rx_byte_o), 32'h55);
      checkOutput("frame55Latency", 32'((recvCycle - frameStart >= 154) && (recvCycle - frameStart <= 156)), 32'd1);
      checkOutput("frame55BusyAfter", 32'(is_receiving_o), 32'd0);

      applyStimulus(8'hA3, 1'b1);
      waitCycles(4);
      checkOutput("frameA3Count", 32'(recvCount), 32'd2);
      checkOutput("frameA3Byte", 32'(rx_byte_o), 32'hA3);

      rx_i = 1'b0;
      waitCycles(5);
      rx_i = 1'b1;
      checkOutput("falseStartBusy", 32'(is_receiving_o), 32'd1);
      waitCycles(7);
      checkOutput("falseStartIdle", 32'(is_receiving_o), 32'd0);
      waitCycles(20);
      checkOutput("falseStartRecv", 32'(recvCount), 32'd2);
      checkOutput("falseStartErr", 32'(errCount), 32'd0);
      checkOutput("falseStartByte", 32'(rx_byte_o), 32'hA3);

      applyStimulus(8'h3C, 1'b0);
      waitCycles(100);
      checkOutput("breakErrDuring", 32'(errCount), 32'd1);
      rx_i = 1'b1;
      waitCycles(20);
      checkOutput("framingErrCount", 32'(errCount), 32'd1);
      checkOutput("framingRecvCount", 32'(recvCount), 32'd2);
      checkOutput("framingByteKept", 32'(rx_byte_o), 32'hA3);

      applyStimulus(8'h81, 1'b1);
      waitCycles(4);
      checkOutput("frame81Count", 32'(recvCount), 32'd3);
      checkOutput("frame81Byte", 32'(rx_byte_o), 32'h81);

      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      applyStimulus(8'h5A, 1'b1);
      waitCycles(5);
      checkOutput("b2bCount", 32'(recvCount), 32'd6);
      checkOutput("b2bByte0", 32'(byteLog[3]), 32'h00);
      checkOutput("b2bByte1", 32'(byteLog[4]), 32'hFF);
      checkOutput("b2bByte2", 32'(byteLog[5]), 32'h5A);
      checkOutput("b2bErr", 32'(errCount), 32'd1);

      abortData = 8'h96;
      rx_i = 1'b0;
      waitCycles(CPB);
      for (int k = 0; k < 4; k++) begin
         rx_i = abortData[k];
         waitCycles(CPB);
      end
      rx_i = abortData[4];
      waitCycles(8);
      checkOutput("abortBusyBefore", 32'(is_receiving_o), 32'd1);
      rst_n = 1'b0;
      rx_i  = 1'b1;
      waitCycles(3);
      checkOutput("abortResetByte", 32'(rx_byte_o), 32'h00);
      checkOutput("abortResetBusy", 32'(is_receiving_o), 32'd0);
      rst_n = 1'b1;
      waitCycles(20);
      checkOutput("abortRecvCount", 32'(recvCount), 32'd6);
      checkOutput("abortErrCount", 32'(errCount), 32'd1);

      applyStimulus(8'h42, 1'b1);
      waitCycles(4);
      checkOutput("frame42Count", 32'(recvCount), 32'd7);
      checkOutput("frame42Byte", 32'(rx_byte_o), 32'h42);
      checkOutput("strobeOverlap", 32'(overlapCount), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive front-end for the UART peripheral. It synchronises the asynchronous rx pin, detects and validates start bits, and samples 8N1 frames at mid-bit. It delivers a received byte, a one-cycle `received` strobe, a busy flag and a framing-error strobe. It feeds the receive side of the bus-facing UART wrapper (rx_byte, received, is_receiving, recv_error) directly.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 4
SYNC_STAGES, 2, flops in rx input synchroniser; legal range >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_i  input  1  raw serial line, idle high, asynchronous to clk
rx_byte_o  output  8  last correctly framed byte, LSB received first
received_o  output  1  one-cycle strobe: rx_byte_o just updated with a good frame
is_receiving_o  output  1  high while a frame is in progress
recv_error_o  output  1  one-cycle strobe: stop bit sampled low (framing error)

Behaviour:
- Reset state: async, active-low, applies at any time including mid-frame.
  - Synchroniser flops reset to 1.
  - State = IDLE; bit/cycle counters = 0.
  - rx_byte_o = 8'h00; received_o = 0; is_receiving_o = 0; recv_error_o = 0.
  - A partial frame is discarded with no strobe.
- rx_s is the last synchroniser stage. rx_i reaches rx_s SYNC_STAGES edges after it changes. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2 (integer division). The counter is $clog2(CLKS_PER_BIT) bits wide and is never compared past CLKS_PER_BIT-1.
- State IDLE:
  - At edge T0, the first edge where rx_s==0, go to START, set is_receiving_o=1 and clear the counter.
- State START:
  - At edge T0+HALF, sample rx_s.
  - rx_s==1: false start. Go to IDLE, is_receiving_o=0, no strobe.
  - rx_s==0: go to DATA with bit index 0.
- State DATA:
  - Data bit k (k=0..7) is sampled at edge T0+HALF+(k+1)*CLKS_PER_BIT.
  - Each sample shifts into an internal shift register, LSB first.
  - After k=7, go to STOP.
- State STOP: sample at edge T0+HALF+9*CLKS_PER_BIT.
  - rx_s==1: load rx_byte_o from the shift register, pulse received_o for exactly the following cycle, set is_receiving_o=0, go to IDLE.
  - rx_s==0: rx_byte_o is unchanged, pulse recv_error_o for the following cycle, set is_receiving_o=0, go to BREAK.
- State BREAK:
  - Wait until rx_s==1, then go to IDLE.
  - A held-low line (break) produces exactly one recv_error_o and no further frames.
- Back-to-back frames: IDLE may detect the next start edge on the cycle after the stop sample. No dead time beyond that.
- received_o and recv_error_o are mutually exclusive and never high in consecutive cycles for one frame.
- The shift register is not visible externally. rx_byte_o holds its value until the next good frame or reset.
- No bus handshake: the consumer must latch on the received_o strobe.

Test Plan:
- All scenarios use CLKS_PER_BIT=16, SYNC_STAGES=2 and a bit period of 16 clk.
- Reset values:
  - Hold rst_n=0 with rx_i toggling.
  - Required: rx_byte_o=8'h00, all strobes 0, is_receiving_o=0.
- Single good frame:
  - Send 0x55, then 0xA3 (start, 8 data LSB-first, stop).
  - Required: one received_o pulse per frame, rx_byte_o=8'h55 then 8'hA3.
  - Required: received_o rises 2+8+9*16 edges after rx_i falls (±1 cycle of sync phase); is_receiving_o high throughout the frame.
- False start:
  - Drive rx_i low for 5 clk, then high.
  - Required: no strobe; is_receiving_o returns to 0 by 8 edges after T0; rx_byte_o unchanged.
- Framing error and break:
  - Send 0x3C with the stop bit low, then hold rx_i low for 100 clk, then release.
  - Required: exactly one recv_error_o pulse, no received_o, rx_byte_o keeps its prior value.
  - Then send 0x81: required received_o with rx_byte_o=8'h81.
- Back-to-back:
  - Send 0x00, 0xFF, 0x5A with zero idle between stop and next start.
  - Required: three received_o pulses, bytes in order, no recv_error_o.
- Reset mid-frame:
  - Assert rst_n=0 during data bit 4 of 0x96, release, then send 0x42.
  - Required: no strobe for the aborted frame; received_o with rx_byte_o=8'h42.
